bus_reg_bank: RTL and testbench
===============================

# bus_reg_bank

Parametrised register bank on the 16-bit FPGA bus, successor to the fixed four-register block. Provides NUM_REGS registers of BUS_WIDTH bits, each with its own access mode: read/write, read-only, write-1-to-clear sticky status, or write pulse. Adds per-register write strobes, an aggregated interrupt, and an error pulse for out-of-range addresses. Sits between the bus decoder (chip select) and application logic.

## Interface
- BUS_WIDTH, 16: data width; 8, 16 or 32.
- NUM_REGS, 4: register count, 1..64.
- ADDR_WIDTH, 8: width of the byte address.
- REG_MODE, all zero: packed, 2 bits per register, register i at [2i+1:2i]. 00 RW, 01 RO, 10 W1C, 11 PULSE.
- REG_INIT, all zero: packed, BUS_WIDTH bits per register. Reset value for RW registers.
- i_Bus_Clk  in  1  bus clock; the only clock.
- i_Bus_Rst_L  in  1  reset; synchronous, active-low.
- i_Bus_CS  in  1  chip select; one command per cycle while high.
- i_Bus_Wr_Rd_n  in  1  1 = write, 0 = read.
- i_Bus_Addr8  in  ADDR_WIDTH  byte address.
- i_Bus_Wr_Data  in  BUS_WIDTH  write data.
- o_Bus_Rd_Data  out  BUS_WIDTH  read data.
- o_Bus_Rd_DV  out  1  read data valid pulse.
- o_Bus_Err  out  1  out-of-range access pulse.
- i_Reg_Flat  in  NUM_REGS*BUS_WIDTH  RO sources.
- i_Set_Flat  in  NUM_REGS*BUS_WIDTH  W1C set events, per bit.
- o_Reg_Flat  out  NUM_REGS*BUS_WIDTH  register contents.
- o_Wr_Strobe  out  NUM_REGS  one-cycle pulse per accepted write.
- o_Irq  out  1  OR of all W1C bits.

## Operation
- Index = i_Bus_Addr8 >> log2(BUS_WIDTH/8). The byte-offset bits are ignored.
- Command accepted on a rising edge with i_Bus_CS=1. There is no back-pressure.
- Write, index < NUM_REGS:
  - o_Wr_Strobe[index] pulses.
  - RW: register loads the data.
  - RO: data discarded; strobe still pulses.
  - W1C: bit cleared wherever the data bit is 1.
  - PULSE: o_Reg_Flat slice carries the data for exactly one cycle, then returns to 0.
- Read, index < NUM_REGS:
  - o_Bus_Rd_DV pulses.
  - Returned value per mode: RW gives the stored value; RO gives the sampled i_Reg_Flat slice; W1C gives the sticky bits; PULSE gives 0.
  - Reads have no side effects.
- Index >= NUM_REGS:
  - o_Bus_Err pulses and no state changes.
  - A read also pulses o_Bus_Rd_DV with data 0, so the master never hangs.
- W1C set: any 1 on i_Set_Flat sets that bit, regardless of bus activity.
  - Set and write-1-clear on the same bit in the same cycle: the set wins and the bit stays 1.
- RO slices of o_Reg_Flat mirror i_Reg_Flat one cycle late (registered).

## Timing
- Reset values:
  - RW registers = REG_INIT.
  - W1C and PULSE registers = 0.
  - o_Bus_Rd_Data = 0, o_Bus_Rd_DV = 0, o_Bus_Err = 0, o_Wr_Strobe = 0, o_Irq = 0.
- Reset is sampled only on a clock edge. A command in the same cycle as reset is dropped: no DV, no strobe.
- Read latency is 1 cycle. Data and DV are registered together, and data holds its last value when DV=0.
- Write effect, o_Wr_Strobe and o_Bus_Err appear 1 cycle after the accepting edge.
- o_Irq is registered from the W1C state. It rises 2 cycles after a set event and falls 2 cycles after the clearing write.
- Back-to-back commands on consecutive cycles are fully supported. A read immediately after a write to the same RW register returns the new value.

## Structure
- Package bus_reg_pkg holds:
  - mode constants MODE_RW, MODE_RO, MODE_W1C, MODE_PULSE;
  - a function returning the byte-offset shift for a given BUS_WIDTH.
- Sub-module bus_reg_cell: one register with mode-dependent write, set and readback logic, instantiated NUM_REGS times by a generate loop.
- The top level keeps address decode, the read mux, DV/Err generation and the o_Irq reduction.

## Test plan
Configuration: BUS_WIDTH=16, NUM_REGS=6, REG_MODE {0:RW, 1:RO, 2:W1C, 3:PULSE, 4:RW, 5:RW}, REG_INIT[0]=0x1234.

- Reset, then read addr 0x00 -> one cycle later DV=1 and data 0x1234. Write 0xBEEF to 0x00, then read 0x01 -> data 0xBEEF (byte offset ignored). Strobe[0] pulses once.
- Drive i_Reg_Flat slice 1 = 0xA5A5, then read 0x02 -> 0xA5A5. Write 0xFFFF to 0x02 -> slice unchanged and strobe[1] pulses.
- Pulse i_Set_Flat slice 2 = 0x0003 -> o_Irq=1 two cycles later. Write 0x0001 to 0x04 -> reads back 0x0002 and o_Irq stays 1. Write 0x0002 -> o_Irq falls.
- Same-cycle set of bit 0 and write 0x0001 to 0x04 -> bit 0 remains 1.
- Write 0x00C3 to 0x06 -> slice 3 = 0x00C3 for exactly one cycle. A read of 0x06 returns 0.
- Read 0x0C (index 6) -> DV=1, data 0 and Err=1. Write 0x0C -> Err=1, no strobe, no state change. Assert reset during a read -> no DV, and all outputs at reset values.

Source files
------------

// File: rtl/bus_reg_pkg.sv
// bus_reg_pkg
//   Shared definitions for the bus register bank:
//   - access mode encodings carried in the packed REG_MODE parameter
//   - byte_shift(): how many low address bits select a byte inside one
//     bus word, i.e. how far the byte address is shifted to get an index
package bus_reg_pkg;

   localparam logic [1:0] MODE_RW    = 2'b00;
   localparam logic [1:0] MODE_RO    = 2'b01;
   localparam logic [1:0] MODE_W1C   = 2'b10;
   localparam logic [1:0] MODE_PULSE = 2'b11;

   // 8-bit bus -> 0, 16-bit -> 1, 32-bit -> 2
   function automatic int byte_shift(input int bus_width);
      return $clog2(bus_width / 8);
   endfunction

endpackage

// File: rtl/bus_reg_cell.sv
// bus_reg_cell
//   One register of the bank. Its behaviour is fixed at elaboration by MODE:
//     RW    : loads wr_data on wr_en, resets to INIT, reads back stored value
//     RO    : samples ro_in every cycle, reads back the sample, ignores writes
//     W1C   : sticky bits set by set_in, cleared by writing 1s; set wins
//     PULSE : presents wr_data for one cycle after a write, else 0; reads 0
// Ports
//   clk      : bus clock
//   rst_n    : synchronous active-low reset
//   wr_en    : accepted bus write addressed to this register
//   wr_data  : bus write data
//   ro_in    : read-only source (RO mode)
//   set_in   : per-bit set events (W1C mode)
//   value    : registered contents, drives the o_Reg_Flat slice
//   rd_value : value returned on a bus read
//   strobe   : one-cycle pulse after every accepted write
module bus_reg_cell
   import bus_reg_pkg::*;
#(
   parameter int                   BUS_WIDTH = 16,
   parameter logic [1:0]           MODE      = MODE_RW,
   parameter logic [BUS_WIDTH-1:0] INIT      = '0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 wr_en,
   input  logic [BUS_WIDTH-1:0] wr_data,
   input  logic [BUS_WIDTH-1:0] ro_in,
   input  logic [BUS_WIDTH-1:0] set_in,
   output logic [BUS_WIDTH-1:0] value,
   output logic [BUS_WIDTH-1:0] rd_value,
   output logic                 strobe
);

   // Only RW registers carry a programmable reset value.
   localparam logic [BUS_WIDTH-1:0] RESET_VALUE = (MODE == MODE_RW) ? INIT : '0;

   logic [BUS_WIDTH-1:0] value_reg;
   logic [BUS_WIDTH-1:0] value_next;
   logic                 strobe_reg;

   always_comb begin
      value_next = value_reg;
      case (MODE)
         MODE_RW:  if (wr_en) value_next = wr_data;
         MODE_RO:  value_next = ro_in;
         // The OR with set_in comes last so a same-cycle set beats the clear.
         MODE_W1C: value_next = (value_reg & ~(wr_en ? wr_data : '0)) | set_in;
         default:  value_next = wr_en ? wr_data : '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         value_reg  <= RESET_VALUE;
         strobe_reg <= 1'b0;
      end else begin
         value_reg  <= value_next;
         strobe_reg <= wr_en;
      end
   end

   assign value    = value_reg;
   assign rd_value = (MODE == MODE_PULSE) ? '0 : value_reg;
   assign strobe   = strobe_reg;

endmodule

// File: rtl/bus_reg_bank.sv
// bus_reg_bank
//   Parametrised register bank on the FPGA bus. NUM_REGS registers of
//   BUS_WIDTH bits, each with an access mode taken from REG_MODE.
// Ports
//   i_Bus_Clk, i_Bus_Rst_L       : clock, synchronous active-low reset
//   i_Bus_CS, i_Bus_Wr_Rd_n      : command strobe and direction (1 = write)
//   i_Bus_Addr8, i_Bus_Wr_Data   : byte address and write data
//   o_Bus_Rd_Data, o_Bus_Rd_DV   : registered read data and its valid pulse
//   o_Bus_Err                    : pulse for a command beyond NUM_REGS
//   i_Reg_Flat, i_Set_Flat       : RO sources and W1C set events, flattened
//   o_Reg_Flat                   : all register contents, flattened
//   o_Wr_Strobe                  : per-register write pulse
//   o_Irq                        : registered OR of every W1C bit
module bus_reg_bank
   import bus_reg_pkg::*;
#(
   parameter int                            BUS_WIDTH  = 16,
   parameter int                            NUM_REGS   = 4,
   parameter int                            ADDR_WIDTH = 8,
   parameter logic [2*NUM_REGS-1:0]         REG_MODE   = '0,
   parameter logic [NUM_REGS*BUS_WIDTH-1:0] REG_INIT   = '0
) (
   input  logic                            i_Bus_Clk,
   input  logic                            i_Bus_Rst_L,
   input  logic                            i_Bus_CS,
   input  logic                            i_Bus_Wr_Rd_n,
   input  logic [ADDR_WIDTH-1:0]           i_Bus_Addr8,
   input  logic [BUS_WIDTH-1:0]            i_Bus_Wr_Data,
   output logic [BUS_WIDTH-1:0]            o_Bus_Rd_Data,
   output logic                            o_Bus_Rd_DV,
   output logic                            o_Bus_Err,
   input  logic [NUM_REGS*BUS_WIDTH-1:0]   i_Reg_Flat,
   input  logic [NUM_REGS*BUS_WIDTH-1:0]   i_Set_Flat,
   output logic [NUM_REGS*BUS_WIDTH-1:0]   o_Reg_Flat,
   output logic [NUM_REGS-1:0]             o_Wr_Strobe,
   output logic                            o_Irq
);

   localparam int SHIFT = byte_shift(BUS_WIDTH);

   logic [ADDR_WIDTH-1:0] index;
   logic [NUM_REGS-1:0]   hit;
   logic [NUM_REGS-1:0]   wr_en;
   logic [NUM_REGS-1:0]   w1c_any;
   logic [BUS_WIDTH-1:0]  rd_vals [NUM_REGS];
   logic [BUS_WIDTH-1:0]  rd_mux;
   logic                  in_range;
   logic                  rd_cmd;

   logic [BUS_WIDTH-1:0]  rd_data_reg;
   logic                  rd_dv_reg;
   logic                  err_reg;
   logic                  irq_reg;

   // Byte-offset bits drop out here, so 0x00 and 0x01 hit the same word.
   assign index    = i_Bus_Addr8 >> SHIFT;
   assign in_range = |hit;
   assign rd_cmd   = i_Bus_CS & ~i_Bus_Wr_Rd_n;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
         localparam logic [1:0] MODE = REG_MODE[2*gi +: 2];

         assign hit[gi]   = (index == ADDR_WIDTH'(gi));
         // Gating with reset drops a command that coincides with reset.
         assign wr_en[gi] = i_Bus_Rst_L & i_Bus_CS & i_Bus_Wr_Rd_n & hit[gi];

         bus_reg_cell #(
            .BUS_WIDTH (BUS_WIDTH),
            .MODE      (MODE),
            .INIT      (REG_INIT[gi*BUS_WIDTH +: BUS_WIDTH])
         ) u_cell (
            .clk      (i_Bus_Clk),
            .rst_n    (i_Bus_Rst_L),
            .wr_en    (wr_en[gi]),
            .wr_data  (i_Bus_Wr_Data),
            .ro_in    (i_Reg_Flat[gi*BUS_WIDTH +: BUS_WIDTH]),
            .set_in   (i_Set_Flat[gi*BUS_WIDTH +: BUS_WIDTH]),
            .value    (o_Reg_Flat[gi*BUS_WIDTH +: BUS_WIDTH]),
            .rd_value (rd_vals[gi]),
            .strobe   (o_Wr_Strobe[gi])
         );

         assign w1c_any[gi] = (MODE == MODE_W1C) ? |o_Reg_Flat[gi*BUS_WIDTH +: BUS_WIDTH] : 1'b0;
      end
   endgenerate

   // One-hot OR mux; an out-of-range index hits nothing and yields 0.
   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (hit[i]) rd_mux = rd_mux | rd_vals[i];
      end
   end

   always_ff @(posedge i_Bus_Clk) begin
      if (!i_Bus_Rst_L) begin
         rd_data_reg <= '0;
         rd_dv_reg   <= 1'b0;
         err_reg     <= 1'b0;
         irq_reg     <= 1'b0;
      end else begin
         rd_dv_reg <= rd_cmd;
         if (rd_cmd) rd_data_reg <= rd_mux;
         err_reg   <= i_Bus_CS & ~in_range;
         irq_reg   <= |w1c_any;
      end
   end

   assign o_Bus_Rd_Data = rd_data_reg;
   assign o_Bus_Rd_DV   = rd_dv_reg;
   assign o_Bus_Err     = err_reg;
   assign o_Irq         = irq_reg;

endmodule

// File: tb/tb_bus_reg_bank.sv
// tb_bus_reg_bank
//   Directed bench for bus_reg_bank (16-bit bus, 6 registers:
//   RW, RO, W1C, PULSE, RW, RW; register 0 initialised to 0x1234).
//   Read data and error pulses are checked by a scoreboard monitor;
//   side-band outputs (strobes, flat contents, irq) are checked inline.
module tb_bus_reg_bank;

   localparam int BW = 16;
   localparam int NR = 6;
   localparam int AW = 8;
   localparam logic [2*NR-1:0]  MODES = 12'h0E4;
   localparam logic [NR*BW-1:0] INITS = 96'h1234;

   logic             clk = 1'b0;
   logic             rst_l;
   logic             cs;
   logic             wr;
   logic [AW-1:0]    addr;
   logic [BW-1:0]    wdata;
   logic [BW-1:0]    rd_data;
   logic             rd_dv;
   logic             err;
   logic [NR*BW-1:0] reg_in;
   logic [NR*BW-1:0] set_in;
   logic [NR*BW-1:0] reg_out;
   logic [NR-1:0]    strobe;
   logic             irq;

   int checks = 0;
   int errors = 0;

   logic [BW-1:0] rd_q [$];
   logic          err_q [$];   // expected o_Bus_Rd_DV alongside each error pulse

   always #5 clk = ~clk;

   bus_reg_bank #(
      .BUS_WIDTH (BW),
      .NUM_REGS  (NR),
      .ADDR_WIDTH(AW),
      .REG_MODE  (MODES),
      .REG_INIT  (INITS)
   ) dut (
      .i_Bus_Clk     (clk),
      .i_Bus_Rst_L   (rst_l),
      .i_Bus_CS      (cs),
      .i_Bus_Wr_Rd_n (wr),
      .i_Bus_Addr8   (addr),
      .i_Bus_Wr_Data (wdata),
      .o_Bus_Rd_Data (rd_data),
      .o_Bus_Rd_DV   (rd_dv),
      .o_Bus_Err     (err),
      .i_Reg_Flat    (reg_in),
      .i_Set_Flat    (set_in),
      .o_Reg_Flat    (reg_out),
      .o_Wr_Strobe   (strobe),
      .o_Irq         (irq)
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end else begin
         $display("ok   %s = %0h", name, act);
      end
   endtask

   // Inputs change just after the falling edge, so each command is applied
   // across exactly one rising edge; on return its registered results are visible.
   task automatic cmd(input logic w, input logic [AW-1:0] a, input logic [BW-1:0] d);
      cs = 1'b1; wr = w; addr = a; wdata = d;
      @(negedge clk);
      cs = 1'b0;
   endtask

   task automatic rd(input logic [AW-1:0] a, input logic [BW-1:0] exp);
      rd_q.push_back(exp);
      cmd(1'b0, a, '0);
   endtask

   task automatic idle(input int n);
      cs = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (rd_dv) begin
         if (rd_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_dv actual=1 required=0 data=%0h", rd_data);
         end else begin
            check("rd_data", rd_data, rd_q.pop_front());
         end
      end
      if (err) begin
         if (err_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_err actual=1 required=0");
         end else begin
            check("err_dv", rd_dv, err_q.pop_front());
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_l = 1'b0; cs = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
      reg_in = '0; set_in = '0;
      @(negedge clk);
      idle(3);
      check("rst_rd_data", rd_data, 0);
      check("rst_dv", rd_dv, 0);
      check("rst_err", err, 0);
      check("rst_strobe", strobe, 0);
      check("rst_irq", irq, 0);
      check("rst_flat", reg_out, 96'h1234);
      rst_l = 1'b1;
      idle(1);

      // RW register 0, byte offset ignored, read-after-write
      rd(8'h00, 16'h1234);
      cmd(1'b1, 8'h00, 16'hBEEF);
      check("wr0_strobe", strobe, 6'b000001);
      rd(8'h01, 16'hBEEF);
      check("wr0_strobe_once", strobe, 6'b000000);

      // RO register 1
      reg_in[1*BW +: BW] = 16'hA5A5;
      idle(1);
      rd(8'h02, 16'hA5A5);
      cmd(1'b1, 8'h02, 16'hFFFF);
      check("ro_strobe", strobe, 6'b000010);
      check("ro_slice", reg_out[1*BW +: BW], 16'hA5A5);
      rd(8'h02, 16'hA5A5);

      // W1C register 2 and irq timing
      set_in[2*BW +: BW] = 16'h0003;
      @(negedge clk);
      set_in = '0;
      check("w1c_set", reg_out[2*BW +: BW], 16'h0003);
      check("irq_lag", irq, 0);
      idle(1);
      check("irq_rise", irq, 1);
      cmd(1'b1, 8'h04, 16'h0001);
      check("w1c_clr0", reg_out[2*BW +: BW], 16'h0002);
      rd(8'h04, 16'h0002);
      check("irq_hold", irq, 1);
      cmd(1'b1, 8'h04, 16'h0002);
      check("w1c_clr1", reg_out[2*BW +: BW], 16'h0000);
      check("irq_fall_lag", irq, 1);
      idle(1);
      check("irq_fall", irq, 0);

      // Set and clear of the same bit in one cycle: set wins
      set_in[2*BW +: BW] = 16'h0001;
      cmd(1'b1, 8'h04, 16'h0001);
      set_in = '0;
      rd(8'h04, 16'h0001);
      cmd(1'b1, 8'h04, 16'h0001);

      // PULSE register 3
      cmd(1'b1, 8'h06, 16'h00C3);
      check("pulse_on", reg_out[3*BW +: BW], 16'h00C3);
      idle(1);
      check("pulse_off", reg_out[3*BW +: BW], 16'h0000);
      rd(8'h06, 16'h0000);

      // RW registers 4 and 5, back to back
      cmd(1'b1, 8'h08, 16'h1111);
      cmd(1'b1, 8'h0A, 16'h2222);
      check("wr5_strobe", strobe, 6'b100000);
      rd(8'h08, 16'h1111);
      rd(8'h0B, 16'h2222);

      // Out of range, index 6
      err_q.push_back(1'b1);
      rd(8'h0C, 16'h0000);
      err_q.push_back(1'b0);
      cmd(1'b1, 8'h0C, 16'hFFFF);
      check("oor_strobe", strobe, 6'b000000);
      check("oor_state", reg_out, {16'h2222, 16'h1111, 16'h0000, 16'h0000, 16'hA5A5, 16'hBEEF});
      idle(2);

      // Reset asserted together with a read: command dropped
      reg_in = '0;
      idle(1);
      rst_l = 1'b0;
      cmd(1'b0, 8'h00, '0);
      check("rst_cmd_dv", rd_dv, 0);
      check("rst_cmd_data", rd_data, 0);
      check("rst_cmd_err", err, 0);
      check("rst_cmd_strobe", strobe, 0);
      check("rst_cmd_irq", irq, 0);
      check("rst_cmd_flat", reg_out, 96'h1234);
      rst_l = 1'b1;
      idle(2);

      check("rd_q_empty", rd_q.size(), 0);
      check("err_q_empty", err_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
